psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
Sequenced two-requester arbiter in front of the PSRAM controller, replacing the combinational OR-mux. Each requester holds a level request and receives a one-cycle acknowledge. The arbiter issues exactly one read8/write8 pulse per granted transaction and tracks controller busy to completion. It returns read data to the granted requester only. It sits between the primary/secondary PSRAM users and the psram controller client port.

Parameters:
ADDR_W, 22, PSRAM byte address width
DATA_W, 8, data width
BUSY_TIMEOUT, 255, max cycles waiting for busy to rise after a command pulse before retiring it as failed (1..255)
STARVE_LIMIT, 4, consecutive pri grants before sec is forced (used only with fairness feature)

Ports:
i_CLK  in  1  system clock; all logic on rising edge
i_RST  in  1  reset, synchronous, active-high
i_pri_req  in  1  primary request level; held until o_pri_ack
i_pri_we  in  1  1=write, 0=read; stable while req
i_pri_addr  in  ADDR_W  byte address; stable while req
i_pri_wdata  in  DATA_W  write data; stable while req
o_pri_ack  out  1  one-cycle completion strobe
o_pri_rdata  out  DATA_W  read data; valid at ack, held until next pri read ack
i_sec_req, i_sec_we, i_sec_addr, i_sec_wdata, o_sec_ack, o_sec_rdata: same as pri, secondary port
o_ps_address  out  ADDR_W  to controller address
o_ps_write8  out  1  one-cycle write command
o_ps_read8  out  1  one-cycle read command
o_ps_wdata  out  DATA_W  to controller write_data
i_ps_rdata  in  DATA_W  controller read_data
i_ps_busy  in  1  controller busy
o_err  out  1  sticky: set on busy timeout; cleared by reset only

Behaviour:
- Reset values: all outputs 0, rdata regs 0, state IDLE, grant=none, starve counter 0.
- States:
  - IDLE: when i_ps_busy=0 and any req is high, latch owner, we, addr, wdata into regs, then go to ISSUE. Fixed priority: pri wins on simultaneous req.
  - ISSUE: assert read8 or write8 for exactly 1 cycle. Address/wdata come from the latched regs and are held through WAIT_LO. Go to WAIT_HI.
  - WAIT_HI: when busy=1, go to WAIT_LO. If busy has not risen after BUSY_TIMEOUT cycles, set o_err, pulse owner ack with rdata unchanged, and go to IDLE.
  - WAIT_LO: when busy=0, capture i_ps_rdata into owner rdata reg (reads only), and go to DONE.
  - DONE: pulse owner ack for 1 cycle, then go to IDLE.
- Latency: req seen in IDLE -> command pulse 1 cycle later. Ack follows busy fall by 2 cycles. Minimum request-to-ack latency = 4 + busy duration.
- Requester drops req before ack: transaction still completes and ack still pulses. Requesters must not do this.
- Req held high through ack cycle: treated as a new request. A requester deasserts req in the ack cycle to avoid a repeat. IDLE samples req one cycle after ack.
- Non-owner rdata and ack never change during another port's transaction.
- o_ps_address/o_ps_wdata are 0 in IDLE (no z drive).
- i_RST asserted mid-transaction: return to IDLE next edge and drop the command. No ack is issued; the controller finishes its own operation. IDLE's busy=0 gate prevents overlap.

Optional Feature:
PSRAM_ARB_FAIR_EN
- Defined: a 3-bit saturating counter counts consecutive pri grants taken while sec req=1. When it reaches STARVE_LIMIT, the next arbitration grants sec and clears the counter. A sec grant or sec req low also clears it.
- Undefined: pure fixed priority, no counter logic.

Decomposition:
- Package psram_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE)
  - owner enum (OWN_PRI, OWN_SEC)
  - default width localparams
- Sub-module psram_arb_select: combinational priority/fairness grant decision, containing the starve counter under the macro. The top FSM stays in psram_arbiter.

Test Plan:
- pri write addr 0x12345 data 0xA5; controller busy high 3 cycles -> one write8 pulse with address 0x12345 and wdata 0xA5; o_pri_ack 2 cycles after busy falls; o_sec_ack stays 0.
- sec read addr 0x3FFFFF; controller returns 0x5C -> o_sec_rdata=0x5C at ack; o_pri_rdata unchanged.
- pri and sec req in the same cycle -> pri served first, sec issued after pri ack with no overlapping commands. With the macro and STARVE_LIMIT=4, continuous pri+sec req -> grant pattern 4 pri then 1 sec, repeating.
- busy never rises, BUSY_TIMEOUT=8 -> ack 8 cycles after WAIT_HI entry, o_err=1 and sticky until i_RST.
- i_RST during WAIT_LO -> next cycle all outputs 0, no ack. A new req after busy falls is served normally.
- busy=1 at request time (external owner) -> no command until busy=0, then command issued next cycle.

Source files
------------

// File: rtl/psram_arb_pkg.sv
// Shared types and default widths for the two-requester PSRAM arbiter.
// Imported by psram_arb_select and psram_arbiter.
package psram_arb_pkg;

  localparam int DEF_ADDR_W       = 22;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_BUSY_TIMEOUT = 255;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic {
    OWN_PRI = 1'b0,
    OWN_SEC = 1'b1
  } owner_t;

endpackage

// File: rtl/psram_arb_select.sv
// Grant decision for the PSRAM arbiter: fixed priority to the primary port,
// optionally with a starvation guard for the secondary port (PSRAM_ARB_FAIR_EN).
module psram_arb_select
  import psram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
`ifdef PSRAM_ARB_FAIR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   take,
`endif
  input  logic   pri_req,
  input  logic   sec_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

  // Limits outside 1..7 cannot be represented by the 3-bit starve counter.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_starve_limit_out_of_range
  end

`ifdef PSRAM_ARB_FAIR_EN
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt;
  logic       force_sec;

  assign force_sec = sec_req && (starve_cnt >= STARVE_MAX);

  always_comb begin
    grant_valid = pri_req | sec_req;
    grant_owner = (sec_req && (!pri_req || force_sec)) ? OWN_SEC : OWN_PRI;
  end

  // Counts primary grants taken while the secondary port was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (!sec_req) begin
      starve_cnt <= 3'd0;
    end else if (take) begin
      if (grant_owner == OWN_SEC) begin
        starve_cnt <= 3'd0;
      end else if (starve_cnt != 3'd7) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  always_comb begin
    grant_valid = pri_req | sec_req;
    grant_owner = (sec_req && !pri_req) ? OWN_SEC : OWN_PRI;
  end
`endif

endmodule

// File: rtl/psram_arbiter.sv
// Sequenced two-port arbiter in front of the PSRAM controller client port.
// Optional secondary-port starvation guard enabled by defining PSRAM_ARB_FAIR_EN.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              i_CLK,
  input  logic              i_RST,

  input  logic              i_pri_req,
  input  logic              i_pri_we,
  input  logic [ADDR_W-1:0] i_pri_addr,
  input  logic [DATA_W-1:0] i_pri_wdata,
  output logic              o_pri_ack,
  output logic [DATA_W-1:0] o_pri_rdata,

  input  logic              i_sec_req,
  input  logic              i_sec_we,
  input  logic [ADDR_W-1:0] i_sec_addr,
  input  logic [DATA_W-1:0] i_sec_wdata,
  output logic              o_sec_ack,
  output logic [DATA_W-1:0] o_sec_rdata,

  output logic [ADDR_W-1:0] o_ps_address,
  output logic              o_ps_write8,
  output logic              o_ps_read8,
  output logic [DATA_W-1:0] o_ps_wdata,
  input  logic [DATA_W-1:0] i_ps_rdata,
  input  logic              i_ps_busy,

  output logic              o_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t              state;
  state_t              next_state;
  owner_t              owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   pri_rdata_q;
  logic [DATA_W-1:0]   sec_rdata_q;
  logic                busy_q;
  logic                err_q;
  logic [7:0]          wait_cnt;

  logic                grant_valid;
  owner_t              grant_owner;
  logic                take;
  logic                timeout;
  logic                capture;

  psram_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
`ifdef PSRAM_ARB_FAIR_EN
    .clk         (i_CLK),
    .rst         (i_RST),
    .take        (take),
`endif
    .pri_req     (i_pri_req),
    .sec_req     (i_sec_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // The live busy gates new grants so an external controller user is never
  // overlapped; the registered copy paces the in-flight transaction.
  assign take    = (state == IDLE) && !i_ps_busy && grant_valid;
  assign timeout = (state == WAIT_HI) && !busy_q && (wait_cnt == TIMEOUT_LAST);
  assign capture = (state == WAIT_LO) && !busy_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (take) next_state = ISSUE;
      ISSUE:   next_state = WAIT_HI;
      WAIT_HI: begin
        if (busy_q) begin
          next_state = WAIT_LO;
        end else if (timeout) begin
          next_state = DONE;
        end
      end
      WAIT_LO: if (!busy_q) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, busy pacing, timeout counter and per-port read data.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      owner_q     <= OWN_PRI;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pri_rdata_q <= '0;
      sec_rdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      busy_q <= i_ps_busy;

      if (take) begin
        owner_q <= grant_owner;
        if (grant_owner == OWN_SEC) begin
          we_q    <= i_sec_we;
          addr_q  <= i_sec_addr;
          wdata_q <= i_sec_wdata;
        end else begin
          we_q    <= i_pri_we;
          addr_q  <= i_pri_addr;
          wdata_q <= i_pri_wdata;
        end
      end

      if (state == ISSUE) begin
        wait_cnt <= 8'd0;
      end else if (state == WAIT_HI) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (timeout) begin
        err_q <= 1'b1;
      end

      if (capture && !we_q) begin
        if (owner_q == OWN_SEC) begin
          sec_rdata_q <= i_ps_rdata;
        end else begin
          pri_rdata_q <= i_ps_rdata;
        end
      end
    end
  end

  always_comb begin
    o_ps_write8  = (state == ISSUE) && we_q;
    o_ps_read8   = (state == ISSUE) && !we_q;
    o_ps_address = (state != IDLE) ? addr_q  : '0;
    o_ps_wdata   = (state != IDLE) ? wdata_q : '0;
    o_pri_ack    = (state == DONE) && (owner_q == OWN_PRI);
    o_sec_ack    = (state == DONE) && (owner_q == OWN_SEC);
    o_pri_rdata  = pri_rdata_q;
    o_sec_rdata  = sec_rdata_q;
    o_err        = err_q;
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed self-checking bench for psram_arbiter with a small PSRAM controller model.
// Define PSRAM_ARB_FAIR_EN to also check the 4-pri/1-sec grant pattern.
module tb_psram_arbiter;

  localparam int ADDR_W       = 22;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 8;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pri_req, pri_we, sec_req, sec_we;
  logic [ADDR_W-1:0] pri_addr, sec_addr;
  logic [DATA_W-1:0] pri_wdata, sec_wdata;
  logic              pri_ack, sec_ack;
  logic [DATA_W-1:0] pri_rdata, sec_rdata;
  logic [ADDR_W-1:0] ps_address;
  logic              ps_write8, ps_read8;
  logic [DATA_W-1:0] ps_wdata, ps_rdata;
  logic              ctrl_busy, ext_busy;
  logic              ps_busy;
  logic              err;

  assign ps_busy = ctrl_busy | ext_busy;

  psram_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_pri_req    (pri_req),
    .i_pri_we     (pri_we),
    .i_pri_addr   (pri_addr),
    .i_pri_wdata  (pri_wdata),
    .o_pri_ack    (pri_ack),
    .o_pri_rdata  (pri_rdata),
    .i_sec_req    (sec_req),
    .i_sec_we     (sec_we),
    .i_sec_addr   (sec_addr),
    .i_sec_wdata  (sec_wdata),
    .o_sec_ack    (sec_ack),
    .o_sec_rdata  (sec_rdata),
    .o_ps_address (ps_address),
    .o_ps_write8  (ps_write8),
    .o_ps_read8   (ps_read8),
    .o_ps_wdata   (ps_wdata),
    .i_ps_rdata   (ps_rdata),
    .i_ps_busy    (ps_busy),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Controller model and monitor state.
  int                busy_len = 3;
  bit                mute = 1'b0;
  logic [DATA_W-1:0] read_val = '0;
  bit                start_next = 1'b0;
  int                busy_left = 0;
  int                cmd_count = 0;
  int                overlap_count = 0;
  int                last_cmd_cyc = -1;
  int                fall_cyc = -1;
  bit                last_cmd_we = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_wdata = '0;
  int                pri_ack_cnt = 0;
  int                sec_ack_cnt = 0;
  bit                ack_seq[$];

  // Controller answers a command pulse with busy for busy_len cycles
  // starting the following cycle, unless muted.
  initial begin
    ctrl_busy = 1'b0;
    ps_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (start_next) begin
        ctrl_busy  = 1'b1;
        busy_left  = busy_len;
        start_next = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          ctrl_busy = 1'b0;
          fall_cyc  = cyc;
        end
      end
      if (ps_read8 || ps_write8) begin
        if (ctrl_busy || ext_busy || (ps_read8 && ps_write8)) overlap_count++;
        cmd_count++;
        last_cmd_cyc = cyc;
        last_cmd_we  = ps_write8;
        last_addr    = ps_address;
        last_wdata   = ps_wdata;
        if (ps_read8) ps_rdata = read_val;
        if (!mute) start_next = 1'b1;
      end
      if (pri_ack) begin
        pri_ack_cnt++;
        ack_seq.push_back(1'b0);
      end
      if (sec_ack) begin
        sec_ack_cnt++;
        ack_seq.push_back(1'b1);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit is_sec, input bit we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    if (is_sec) begin
      sec_we = we; sec_addr = addr; sec_wdata = wdata; sec_req = 1'b1;
    end else begin
      pri_we = we; pri_addr = addr; pri_wdata = wdata; pri_req = 1'b1;
    end
  endtask

  // Polls at negedge for the port's ack and drops the request in the ack cycle.
  task automatic waitAck(input string tag, input bit is_sec, input int max_cyc, output int ack_cyc);
    bit seen;
    seen    = 1'b0;
    ack_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (is_sec ? sec_ack : pri_ack) begin
        ack_cyc = cyc;
        seen    = 1'b1;
        break;
      end
    end
    if (is_sec) sec_req = 1'b0;
    else        pri_req = 1'b0;
    checkOutput({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, a, b, c0, p0, s0, f;

    rst = 1'b1; ext_busy = 1'b0;
    pri_req = 1'b0; pri_we = 1'b0; pri_addr = '0; pri_wdata = '0;
    sec_req = 1'b0; sec_we = 1'b0; sec_addr = '0; sec_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd",   {30'd0, ps_write8, ps_read8}, 32'd0);
    checkOutput("rst_addr",  32'(ps_address), 32'd0);
    checkOutput("rst_acks",  {30'd0, pri_ack, sec_ack}, 32'd0);
    checkOutput("rst_rdata", {16'd0, pri_rdata, sec_rdata}, 32'd0);
    checkOutput("rst_err",   32'(err), 32'd0);
    rst = 1'b0;

    // Primary write, busy 3 cycles.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 22'h12345, 8'hA5);
    r = cyc; c0 = cmd_count;
    waitAck("t1", 1'b0, 40, a);
    checkOutput("t1_cmds",     32'(cmd_count - c0), 32'd1);
    checkOutput("t1_is_write", 32'(last_cmd_we), 32'd1);
    checkOutput("t1_addr",     32'(last_addr), 32'h12345);
    checkOutput("t1_wdata",    32'(last_wdata), 32'hA5);
    checkOutput("t1_ack_after_fall", 32'(a - fall_cyc), 32'd2);
    checkOutput("t1_latency",  32'(a - r), 32'd7);
    checkOutput("t1_no_sec_ack", 32'(sec_ack_cnt), 32'd0);

    // Primary read to give the primary rdata register a known value.
    read_val = 8'h33;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 22'h00100, 8'h00);
    waitAck("t2", 1'b0, 40, a);
    checkOutput("t2_pri_rdata", 32'(pri_rdata), 32'h33);
    checkOutput("t2_is_read",   32'(last_cmd_we), 32'd0);

    // Secondary read at the top address.
    read_val = 8'h5C;
    p0 = pri_ack_cnt;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 22'h3FFFFF, 8'h00);
    waitAck("t3", 1'b1, 40, a);
    checkOutput("t3_sec_rdata", 32'(sec_rdata), 32'h5C);
    checkOutput("t3_pri_rdata_kept", 32'(pri_rdata), 32'h33);
    checkOutput("t3_no_pri_ack", 32'(pri_ack_cnt - p0), 32'd0);
    checkOutput("t3_addr", 32'(last_addr), 32'h3FFFFF);

    // Simultaneous requests: primary first, secondary issued 2 cycles after its ack.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 22'h00001, 8'h11);
    applyStimulus(1'b1, 1'b1, 22'h00002, 8'h22);
    c0 = cmd_count; s0 = sec_ack_cnt;
    waitAck("t4_pri", 1'b0, 40, a);
    checkOutput("t4_sec_not_first", 32'(sec_ack_cnt - s0), 32'd0);
    checkOutput("t4_pri_addr", 32'(last_addr), 32'h1);
    waitAck("t4_sec", 1'b1, 40, b);
    checkOutput("t4_sec_cmd_cyc", 32'(last_cmd_cyc - a), 32'd2);
    checkOutput("t4_sec_addr",  32'(last_addr), 32'h2);
    checkOutput("t4_sec_wdata", 32'(last_wdata), 32'h22);
    checkOutput("t4_cmds",      32'(cmd_count - c0), 32'd2);
    checkOutput("t4_overlap",   32'(overlap_count), 32'd0);

    // Busy never rises: ack 8 cycles after WAIT_HI entry, sticky error.
    mute = 1'b1;
    checkOutput("t5_err_before", 32'(err), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 22'h00200, 8'h00);
    r = cyc;
    waitAck("t5", 1'b0, 40, a);
    checkOutput("t5_latency", 32'(a - r), 32'd10);
    checkOutput("t5_err",     32'(err), 32'd1);
    checkOutput("t5_rdata_unchanged", 32'(pri_rdata), 32'h33);
    mute = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 22'h00210, 8'h5A);
    waitAck("t5b", 1'b0, 40, a);
    checkOutput("t5_err_sticky", 32'(err), 32'd1);

    // Reset while waiting for busy to fall.
    busy_len = 10;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 22'h00333, 8'h3C);
    r = cyc; p0 = pri_ack_cnt;
    repeat (6) @(negedge clk);
    rst = 1'b1; pri_req = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_cmd",   {30'd0, ps_write8, ps_read8}, 32'd0);
    checkOutput("t6_rst_addr",  {2'd0, ps_address, ps_wdata}, 32'd0);
    checkOutput("t6_rst_acks",  {30'd0, pri_ack, sec_ack}, 32'd0);
    checkOutput("t6_rst_rdata", {16'd0, pri_rdata, sec_rdata}, 32'd0);
    checkOutput("t6_rst_err",   32'(err), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("t6_no_ack", 32'(pri_ack_cnt - p0), 32'd0);
    busy_len = 3;
    read_val = 8'h77;
    applyStimulus(1'b1, 1'b0, 22'h000ABC, 8'h00);
    r = cyc;
    waitAck("t6", 1'b1, 40, b);
    checkOutput("t6_sec_rdata", 32'(sec_rdata), 32'h77);
    checkOutput("t6_latency",   32'(b - r), 32'd7);

    // External busy holds off the command until it falls.
    @(negedge clk);
    ext_busy = 1'b1;
    applyStimulus(1'b0, 1'b1, 22'h00444, 8'h44);
    c0 = cmd_count;
    repeat (5) @(negedge clk);
    checkOutput("t7_held_off", 32'(cmd_count - c0), 32'd0);
    ext_busy = 1'b0;
    f = cyc;
    waitAck("t7", 1'b0, 40, a);
    checkOutput("t7_cmd_cyc", 32'(last_cmd_cyc - f), 32'd1);
    checkOutput("t7_addr",    32'(last_addr), 32'h444);
    checkOutput("t7_ack_after_fall", 32'(a - fall_cyc), 32'd2);
    checkOutput("t7_overlap", 32'(overlap_count), 32'd0);

`ifdef PSRAM_ARB_FAIR_EN
    // Both ports request continuously: expect P P P P S repeating.
    busy_len = 2;
    @(negedge clk);
    ack_seq.delete();
    applyStimulus(1'b0, 1'b0, 22'h00010, 8'h00);
    applyStimulus(1'b1, 1'b0, 22'h00020, 8'h00);
    for (int i = 0; i < 300 && ack_seq.size() < 10; i++) @(negedge clk);
    pri_req = 1'b0; sec_req = 1'b0;
    checkOutput("fair_ack_count", 32'(ack_seq.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < ack_seq.size(); i++) begin
      checkOutput($sformatf("fair_grant_%0d", i), 32'(ack_seq[i]), 32'((i % 5) == 4));
    end
    repeat (30) @(negedge clk);
    checkOutput("fair_overlap", 32'(overlap_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
